ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID_EX pipeline register outputs. It accepts one M-extension instruction at a time, computes the result over 32 iteration cycles, and holds the front of the pipeline with `stall_md` until the result is ready. The result is then muxed into the EX result path ahead of EX_MEM.

---
 rtl/ex_muldiv_pkg.sv | 26 ++
 rtl/ex_muldiv.sv | 183 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_ITERS      = 32;
  localparam int MD_CNT_W      = 6;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX. Operands are converted to
// magnitudes on accept, iterated for 32 cycles in a shared 64-bit shift
// register (shift-add multiply / restoring divide), sign-fixed on the edge
// into DONE, and presented for exactly one cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  md_valid_EX,
  input  logic [31:0]           instruction_EX,
  input  logic [DATA_WIDTH-1:0] rs1_data_EX,
  input  logic [DATA_WIDTH-1:0] rs2_data_EX,
  input  logic                  flush_EX,
  output logic [DATA_WIDTH-1:0] md_result_EX,
  output logic                  md_done_EX,
  output logic                  md_busy,
  output logic                  stall_md
);

  localparam int W = DATA_WIDTH;

  // Conditional two's-complement negate used for the final sign fix.
  function automatic logic [2*W-1:0] fix_sign_wide(input logic [2*W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [W-1:0] fix_sign(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q;
  md_op_e              op_q;
  logic                neg_q;
  logic [W-1:0]        b_q;
  logic [2*W-1:0]      acc_q;
  logic [W-1:0]        result_q;
  logic                done_q;

  md_op_e              op_in;
  logic                is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, neg_in;
  logic [W-1:0]        a_mag_in, b_mag_in;
  logic                dz_in, ovf_in, special_in;
  logic [W-1:0]        special_res;
  logic                accept;
  logic                last_iter;

  logic [W:0]          mul_sum;
  logic [2*W-1:0]      mul_nxt;
  logic [W:0]          rem_sh;
  logic [W+1:0]        div_sub;
  logic [2*W-1:0]      div_nxt;
  logic [2*W-1:0]      iter_nxt;
  logic [2*W-1:0]      prod_fix;
  logic [W-1:0]        div_val;
  logic [W-1:0]        calc_res;
  logic                unused_bits;

  assign accept    = md_valid_EX & ~flush_EX;
  assign last_iter = (cnt_q == MD_CNT_W'(MD_ITERS - 1));

  // Decode the incoming op: operand signedness, magnitudes, result sign and
  // the divide corner cases that bypass iteration.
  always_comb begin
    op_in     = md_op_e'(instruction_EX[14:12]);
    is_div_in = instruction_EX[14];
    a_sgn_in  = (op_in == MD_MUL) || (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                (op_in == MD_DIV) || (op_in == MD_REM);
    b_sgn_in  = (op_in == MD_MUL) || (op_in == MD_MULH) ||
                (op_in == MD_DIV) || (op_in == MD_REM);
    a_neg_in  = a_sgn_in & rs1_data_EX[W-1];
    b_neg_in  = b_sgn_in & rs2_data_EX[W-1];
    a_mag_in  = a_neg_in ? -rs1_data_EX : rs1_data_EX;
    b_mag_in  = b_neg_in ? -rs2_data_EX : rs2_data_EX;
    case (op_in)
      MD_DIV:  neg_in = a_neg_in ^ b_neg_in;
      MD_REM:  neg_in = a_neg_in;
      MD_DIVU: neg_in = 1'b0;
      MD_REMU: neg_in = 1'b0;
      default: neg_in = a_neg_in ^ b_neg_in;
    endcase
    dz_in      = is_div_in & (rs2_data_EX == '0);
    ovf_in     = is_div_in & ~instruction_EX[12] &
                 (rs1_data_EX == {1'b1, {(W-1){1'b0}}}) & (rs2_data_EX == '1);
    special_in = dz_in | ovf_in;
    // funct3[1] distinguishes remainder from quotient among divides
    if (dz_in) special_res = instruction_EX[13] ? rs1_data_EX : '1;
    else       special_res = instruction_EX[13] ? '0 : rs1_data_EX;
  end

  // One iteration of either datapath plus the sign-fixed result it implies.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt = {mul_sum, acc_q[W-1:1]};
    rem_sh  = acc_q[2*W-1:W-1];
    div_sub = {1'b0, rem_sh} - {2'b00, b_q};
    if (!div_sub[W+1]) div_nxt = {div_sub[W-1:0], acc_q[W-2:0], 1'b1};
    else               div_nxt = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    iter_nxt = op_q[2] ? div_nxt : mul_nxt;
    prod_fix = fix_sign_wide(iter_nxt, neg_q);
    div_val  = op_q[1] ? iter_nxt[2*W-1:W] : iter_nxt[W-1:0];
    if (op_q[2])              calc_res = fix_sign(div_val, neg_q);
    else if (op_q == MD_MUL)  calc_res = prod_fix[W-1:0];
    else                      calc_res = prod_fix[2*W-1:W];
  end

  assign unused_bits = ^{instruction_EX[31:15], instruction_EX[11:0], div_sub[W]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush abandons any op and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = special_in ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (flush_EX)       state_d = MD_IDLE;
        else if (last_iter) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Control outputs; stall releases in DONE so the op leaves ID_EX then.
  always_comb begin
    md_busy  = (state_q == MD_CALC);
    stall_md = md_valid_EX & ~flush_EX & (state_q != MD_DONE) & ~rst;
  end

  // Operand latch, iteration and the registered one-cycle result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= '0;
      done_q   <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            b_q   <= b_mag_in;
            acc_q <= {{W{1'b0}}, a_mag_in};
            cnt_q <= '0;
            if (special_in) begin
              result_q <= special_res;
              done_q   <= 1'b1;
            end
          end
        end
        MD_CALC: begin
          if (!flush_EX) begin
            acc_q <= iter_nxt;
            cnt_q <= cnt_q + MD_CNT_W'(1);
            if (last_iter) begin
              result_q <= calc_res;
              done_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md_result_EX = result_q;
  assign md_done_EX   = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a per-cycle timeline/arithmetic model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid_EX;
  logic [31:0] instruction_EX;
  logic [31:0] rs1_data_EX;
  logic [31:0] rs2_data_EX;
  logic        flush_EX;
  logic [31:0] md_result_EX;
  logic        md_done_EX;
  logic        md_busy;
  logic        stall_md;

  int total = 0;
  int bad   = 0;
  int pcyc  = 0;
  bit chk_en = 1'b0;

  ex_muldiv #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .md_valid_EX    (md_valid_EX),
    .instruction_EX (instruction_EX),
    .rs1_data_EX    (rs1_data_EX),
    .rs2_data_EX    (rs2_data_EX),
    .flush_EX       (flush_EX),
    .md_result_EX   (md_result_EX),
    .md_done_EX     (md_done_EX),
    .md_busy        (md_busy),
    .stall_md       (stall_md)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    pcyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk_instr(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Architectural RV32M result computed with wide integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Per-cycle compare against the model: an op accepted in cycle t finishes
  // in cycle t+33 (t+1 for the divide corner cases); flush/reset discard it.
  initial begin
    bit          pend;
    bit          pend_sp;
    int          pend_acc, pend_done;
    logic [31:0] pend_res;
    logic        e_done, e_busy, e_stall;
    logic [31:0] e_res;
    pend = 1'b0; pend_sp = 1'b0; pend_acc = 0; pend_done = 0; pend_res = '0;
    forever begin
      @(negedge clk);
      e_done  = pend && (pcyc == pend_done);
      e_busy  = pend && !pend_sp && (pcyc > pend_acc) && (pcyc < pend_done);
      e_stall = md_valid_EX && !flush_EX && !rst && !e_done;
      e_res   = e_done ? pend_res : 32'h0;
      if (chk_en) begin
        check32("cyc done", {31'b0, md_done_EX}, {31'b0, e_done});
        check32("cyc busy", {31'b0, md_busy}, {31'b0, e_busy});
        check32("cyc stall", {31'b0, stall_md}, {31'b0, e_stall});
        check32("cyc result", md_result_EX, e_res);
      end
      if (rst)                pend = 1'b0;
      else if (flush_EX)      pend = 1'b0;
      else if (e_done)        pend = 1'b0;
      else if (!pend && md_valid_EX) begin
        pend      = 1'b1;
        pend_sp   = is_special(instruction_EX[14:12], rs1_data_EX, rs2_data_EX);
        pend_acc  = pcyc;
        pend_done = pcyc + (pend_sp ? 1 : 33);
        pend_res  = ref_md(instruction_EX[14:12], rs1_data_EX, rs2_data_EX);
      end
    end
  end

  // Issue one op, hold it until done, and check result, latency and stalls
  // against hand-computed values.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int lat,
                        output int t_start, output int t_done);
    int          k;
    int          stalls;
    bit          got;
    logic [31:0] res;
    @(posedge clk); #1;
    md_valid_EX    = 1'b1;
    instruction_EX = mk_instr(f3);
    rs1_data_EX    = a;
    rs2_data_EX    = b;
    t_start = pcyc;
    t_done  = -1;
    k = 0; stalls = 0; got = 1'b0; res = '0;
    while (!got && k < 100) begin
      @(negedge clk);
      if (stall_md) stalls++;
      if (md_done_EX) begin
        got    = 1'b1;
        res    = md_result_EX;
        t_done = pcyc;
      end else begin
        k++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done within 100 cycles", nm);
    end else begin
      check32({nm, " result"}, res, want);
      check32({nm, " model"}, ref_md(f3, a, b), want);
      check32({nm, " latency"}, 32'(t_done - t_start), 32'(lat));
      check32({nm, " stalls"}, 32'(stalls), 32'(lat));
    end
  endtask

  task automatic drop_valid();
    @(posedge clk); #1;
    md_valid_EX = 1'b0;
  endtask

  task automatic watch_no_done(input string nm, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (md_done_EX) pulses++;
    end
    check32(nm, 32'(pulses), 32'h0);
  endtask

  initial begin
    int s1, d1, s2, d2;
    rst            = 1'b1;
    md_valid_EX    = 1'b1;
    instruction_EX = mk_instr(3'd0);
    rs1_data_EX    = 32'd7;
    rs2_data_EX    = 32'd3;
    flush_EX       = 1'b0;

    // Reset state, with a valid op pending to show stall is forced low
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check32("reset result", md_result_EX, 32'h0);
    check32("reset done", {31'b0, md_done_EX}, 32'h0);
    check32("reset busy", {31'b0, md_busy}, 32'h0);
    check32("reset stall", {31'b0, stall_md}, 32'h0);
    @(posedge clk); #1;
    rst         = 1'b0;
    md_valid_EX = 1'b0;

    // Multiplies
    run_op("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, s1, d1); drop_valid();
    run_op("MULH", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, s1, d1); drop_valid();
    run_op("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, s1, d1); drop_valid();
    run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, s1, d1); drop_valid();
    run_op("MULH mix", 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33, s1, d1); drop_valid();

    // Divides
    run_op("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, s1, d1); drop_valid();
    run_op("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, s1, d1); drop_valid();
    run_op("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33, s1, d1); drop_valid();
    run_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33, s1, d1); drop_valid();
    run_op("DIVU big", 3'd5, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33, s1, d1); drop_valid();

    // Divide corner cases
    run_op("DIV by0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, s1, d1); drop_valid();
    run_op("REM by0", 3'd6, 32'd5, 32'd0, 32'd5, 1, s1, d1); drop_valid();
    run_op("DIVU by0", 3'd5, 32'd9, 32'd0, 32'hFFFFFFFF, 1, s1, d1); drop_valid();
    run_op("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, s1, d1); drop_valid();
    run_op("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, s1, d1); drop_valid();

    // Back-to-back MULs
    run_op("B2B first", 3'd0, 32'd3, 32'd5, 32'd15, 33, s1, d1);
    run_op("B2B second", 3'd0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 33, s2, d2);
    drop_valid();
    check32("B2B accept cycle", 32'(s2 - s1), 32'd34);
    check32("B2B done cycle", 32'(d2 - s1), 32'd67);

    // Flush during CALC cycle 10
    @(posedge clk); #1;
    md_valid_EX    = 1'b1;
    instruction_EX = mk_instr(3'd0);
    rs1_data_EX    = 32'd3;
    rs2_data_EX    = 32'd4;
    repeat (10) @(posedge clk);
    #1 flush_EX = 1'b1;
    @(negedge clk);
    check32("flush stall", {31'b0, stall_md}, 32'h0);
    @(posedge clk); #1;
    flush_EX    = 1'b0;
    md_valid_EX = 1'b0;
    @(negedge clk);
    check32("flush busy after", {31'b0, md_busy}, 32'h0);
    watch_no_done("flush no done", 40);

    // Reset at cycle 5 of a DIV, then a normal MUL
    @(posedge clk); #1;
    md_valid_EX    = 1'b1;
    instruction_EX = mk_instr(3'd4);
    rs1_data_EX    = 32'd100;
    rs2_data_EX    = 32'd7;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check32("rst stall", {31'b0, stall_md}, 32'h0);
    @(posedge clk); #1;
    rst         = 1'b0;
    md_valid_EX = 1'b0;
    @(negedge clk);
    check32("rst mid result", md_result_EX, 32'h0);
    check32("rst mid done", {31'b0, md_done_EX}, 32'h0);
    check32("rst mid busy", {31'b0, md_busy}, 32'h0);
    watch_no_done("rst no done", 40);
    run_op("MUL after rst", 3'd0, 32'd6, 32'd7, 32'd42, 33, s1, d1); drop_valid();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
